counter_necv: RTL and testbench



---
 rtl/counter_necv_pkg.sv | 20 ++
 rtl/counter_necv.sv | 44 ++++
 tb/tb_counter_necv.sv | 134 +++++++++++++
 3 files changed

// File: rtl/counter_necv_pkg.sv
// Shared helpers for counter_necv: width masks used to derive parameter-dependent constants.
package counter_necv_pkg;

    localparam int unsigned WL_MIN = 1;
    localparam int unsigned WL_MAX = 32;

    function automatic logic [31:0] width_mask(input int unsigned wl);
        logic [31:0] r_mask;
        if (wl >= 32)
            r_mask = '1;
        else
            r_mask = (32'd1 << wl) - 32'd1;
        return r_mask;
    endfunction

    function automatic logic iv_overflows(input int unsigned wl, input logic [31:0] iv);
        return (iv & ~width_mask(wl)) != 32'd0;
    endfunction

endpackage

// File: rtl/counter_necv.sv
// Generic up-counter with synchronous reset/clear to IV, count enable and
// a combinational terminal-count flag decoded straight from the register.
module counter_necv
    import counter_necv_pkg::*;
#(
    parameter int unsigned WL = 8,
    parameter int unsigned IV = 0
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iCLR,
    input  logic          iEN,
    output logic [WL-1:0] oCNT,
    output logic          oTC
);

    localparam logic [WL-1:0] IV_T         = WL'(IV);
    localparam logic [WL-1:0] TC_VAL       = '1;
    localparam bit            IV_TRUNCATED = iv_overflows(WL, IV);

    if ((WL < WL_MIN) || (WL > WL_MAX)) begin : g_bad_wl
        $error("counter_necv: WL=%0d outside 1..32", WL);
    end

    // An oversized IV is legal; only its low WL bits reach IV_T.
    if (IV_TRUNCATED) begin : g_iv_truncated
    end

    logic [WL-1:0] r_cnt;
    logic          w_load_iv;

    assign w_load_iv = iRST | iCLR;

    always_ff @(posedge iCLK) begin
        if (w_load_iv)
            r_cnt <= IV_T;
        else if (iEN)
            r_cnt <= r_cnt + 1'b1;
    end

    assign oCNT = r_cnt;
    assign oTC  = (r_cnt == TC_VAL);

endmodule

// File: tb/tb_counter_necv.sv
// Directed bench for counter_necv: WL=6/IV=0 sweep with self-clear, wrap,
// priority and mid-count reset; WL=4 with IV=5 and an oversized IV=21.
module tb_counter_necv;

    logic       clk;
    logic       rst;
    logic       en6, clr6_man, self_clr, clr6;
    logic [5:0] cnt6;
    logic       tc6;
    logic       en4, clr4;
    logic [3:0] cnt4, cnt4b;
    logic       tc4, tc4b;

    int n_chk  = 0;
    int n_pass = 0;

    assign clr6 = clr6_man | (self_clr && (cnt6 == 6'd35));

    counter_necv #(.WL(6), .IV(0)) u_c6 (
        .iCLK(clk), .iRST(rst), .iCLR(clr6), .iEN(en6), .oCNT(cnt6), .oTC(tc6)
    );

    counter_necv #(.WL(4), .IV(5)) u_c4 (
        .iCLK(clk), .iRST(rst), .iCLR(clr4), .iEN(en4), .oCNT(cnt4), .oTC(tc4)
    );

    counter_necv #(.WL(4), .IV(21)) u_c4b (
        .iCLK(clk), .iRST(rst), .iCLR(clr4), .iEN(en4), .oCNT(cnt4b), .oTC(tc4b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp6;
        int seen35;

        rst = 1'b1; en6 = 1'b1; clr6_man = 1'b0; self_clr = 1'b0;
        en4 = 1'b0; clr4 = 1'b0;

        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_cnt6", 32'(cnt6), 0);
            chk("rst_tc6", 32'(tc6), 0);
        end
        chk("rst_cnt4", 32'(cnt4), 5);
        chk("rst_tc4", 32'(tc4), 0);
        chk("rst_cnt4b_iv21", 32'(cnt4b), 5);

        // Sweep 0..35 with clear driven by the count==35 decode
        rst = 1'b0; self_clr = 1'b1;
        seen35 = 0;
        for (int i = 1; i <= 37; i++) begin
            tick();
            chk("sweep_cnt", 32'(cnt6), 32'(i % 36));
            if (cnt6 == 6'd35) seen35++;
        end
        chk("sweep_35_once", 32'(seen35), 1);
        chk("sweep_tc", 32'(tc6), 0);

        // Free-run from 1 through 63 and wrap to 0
        self_clr = 1'b0;
        exp6 = 1;
        for (int i = 0; i < 63; i++) begin
            tick();
            exp6 = (exp6 + 1) % 64;
            chk("wrap_cnt", 32'(cnt6), 32'(exp6));
            chk("wrap_tc", 32'(tc6), (exp6 == 63) ? 32'd1 : 32'd0);
        end
        chk("wrap_end_zero", 32'(cnt6), 0);

        for (int i = 0; i < 10; i++) tick();
        chk("prio_at10", 32'(cnt6), 10);
        clr6_man = 1'b1;
        tick();
        chk("prio_clr_wins", 32'(cnt6), 0);
        clr6_man = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("prio_count3", 32'(cnt6), 3);
        en6 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_cnt", 32'(cnt6), 3);
        end
        chk("hold_cnt4", 32'(cnt4), 5);

        // WL=4 with IV=5 and IV=21 (truncates to 5)
        en4 = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("iv5_cnt15", 32'(cnt4), 15);
        chk("iv5_tc", 32'(tc4), 1);
        chk("iv21_cnt15", 32'(cnt4b), 15);
        chk("iv21_tc", 32'(tc4b), 1);
        tick();
        chk("iv5_wrap0", 32'(cnt4), 0);
        chk("iv5_tc_off", 32'(tc4), 0);
        tick();
        chk("iv5_cnt1", 32'(cnt4), 1);
        clr4 = 1'b1;
        tick();
        chk("iv5_clr", 32'(cnt4), 5);
        chk("iv21_clr", 32'(cnt4b), 5);
        clr4 = 1'b0; en4 = 1'b0;

        // Reset mid-count at 20
        en6 = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        chk("mid_at20", 32'(cnt6), 20);
        rst = 1'b1;
        tick();
        chk("mid_rst", 32'(cnt6), 0);
        chk("mid_rst_tc", 32'(tc6), 0);
        rst = 1'b0;
        tick();
        chk("mid_resume", 32'(cnt6), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
